// File: rtl/usb_reg_pkg.sv
// usb_reg_pkg: shared constants for the CW305 USB register-bus responder.
//   - FSM state encoding (IDLE, WR_ACTIVE, RD_REQ, RD_DRIVE)
//   - synchroniser depth for strobes and the matching address/data delay
//   - protocol-error counter width and a saturating increment helper
package usb_reg_pkg;

  localparam int unsigned SYNC_DEPTH  = 2;
  localparam int unsigned PROTO_CNT_W = 8;
  localparam int unsigned STATE_W     = 2;

  localparam logic [STATE_W-1:0] ST_IDLE      = 2'd0;
  localparam logic [STATE_W-1:0] ST_WR_ACTIVE = 2'd1;
  localparam logic [STATE_W-1:0] ST_RD_REQ    = 2'd2;
  localparam logic [STATE_W-1:0] ST_RD_DRIVE  = 2'd3;

  localparam logic [PROTO_CNT_W-1:0] PROTO_CNT_MAX = '1;

  // Increment that sticks at the all-ones value.
  function automatic logic [PROTO_CNT_W-1:0] sat_inc(input logic [PROTO_CNT_W-1:0] v);
    return (v == PROTO_CNT_MAX) ? v : v + PROTO_CNT_W'(1);
  endfunction

endpackage

// File: rtl/usb_reg_responder_sync.sv
// usb_strobe_sync: brings one active-low host strobe into the usb_clk domain.
//   usb_clk  : clock
//   rst      : synchronous active-high reset (all flops go to 1 = strobe inactive)
//   strobe_i : asynchronous strobe from the pad
//   level_o  : synchronised strobe level (last synchroniser stage)
//   prev_o   : level_o delayed one more cycle, used by the parent for edge detection
module usb_strobe_sync
  import usb_reg_pkg::*;
(
  input  logic usb_clk,
  input  logic rst,
  input  logic strobe_i,
  output logic level_o,
  output logic prev_o
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;

  // Synchroniser chain plus one edge-detect flop.
  always_ff @(posedge usb_clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], strobe_i};
      prev_q <= sync_q[SYNC_DEPTH-1];
    end
  end

  assign level_o = sync_q[SYNC_DEPTH-1];
  assign prev_o  = prev_q;

endmodule

// File: rtl/usb_reg_responder.sv
// usb_reg_responder: FPGA end of the CW305 parallel USB register bus.
// Converts asynchronous host strobe transactions into single-cycle register
// read/write requests and returns read data to the shared bus.
//   usb_clk, rst          : clock, synchronous active-high reset
//   usb_addr, usb_din     : host address / write data (asynchronous)
//   usb_rdn/wrn/cen       : active-low host strobes (asynchronous)
//   usb_dout, usb_isout   : read data and pad output enable
//   reg_address/bytecnt   : captured register select / byte select
//   reg_datao, reg_datai  : write data out, read data in (valid 1 cycle after reg_read)
//   reg_read, reg_write   : one-cycle request pulses
//   reg_addrvalid         : address outputs hold a live transaction address
//   proto_err_cnt         : saturating count of rdn+wrn both-low events
module usb_reg_responder
  import usb_reg_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH   = 21,
  parameter int unsigned pBYTECNT_SIZE = 7
) (
  input  logic                                  usb_clk,
  input  logic                                  rst,
  input  logic [pADDR_WIDTH-1:0]                usb_addr,
  input  logic [7:0]                            usb_din,
  output logic [7:0]                            usb_dout,
  output logic                                  usb_isout,
  input  logic                                  usb_rdn,
  input  logic                                  usb_wrn,
  input  logic                                  usb_cen,
  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]  reg_address,
  output logic [pBYTECNT_SIZE-1:0]              reg_bytecnt,
  output logic [7:0]                            reg_datao,
  input  logic [7:0]                            reg_datai,
  output logic                                  reg_read,
  output logic                                  reg_write,
  output logic                                  reg_addrvalid,
  output logic [PROTO_CNT_W-1:0]                proto_err_cnt
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned FLUSH_W = $clog2(SYNC_DEPTH + 1);

  // Synchronised strobes
  logic rdn_s, rdn_p, wrn_s, wrn_p, cen_s, cen_p;

  usb_strobe_sync u_sync_rdn (
    .usb_clk  (usb_clk),
    .rst      (rst),
    .strobe_i (usb_rdn),
    .level_o  (rdn_s),
    .prev_o   (rdn_p)
  );

  usb_strobe_sync u_sync_wrn (
    .usb_clk  (usb_clk),
    .rst      (rst),
    .strobe_i (usb_wrn),
    .level_o  (wrn_s),
    .prev_o   (wrn_p)
  );

  usb_strobe_sync u_sync_cen (
    .usb_clk  (usb_clk),
    .rst      (rst),
    .strobe_i (usb_cen),
    .level_o  (cen_s),
    .prev_o   (cen_p)
  );

  logic rdn_fall, rdn_rise, wrn_fall, wrn_rise, cen_rise;
  logic both_low, both_low_prev, illegal;

  assign rdn_fall      = rdn_p & ~rdn_s;
  assign rdn_rise      = ~rdn_p & rdn_s;
  assign wrn_fall      = wrn_p & ~wrn_s;
  assign wrn_rise      = ~wrn_p & wrn_s;
  assign cen_rise      = ~cen_p & cen_s;
  assign both_low      = ~rdn_s & ~wrn_s;
  assign both_low_prev = ~rdn_p & ~wrn_p;

  // Address/data delay line matching the strobe synchroniser depth
  logic [pADDR_WIDTH-1:0] addr_dly_q [SYNC_DEPTH];
  logic [DATA_W-1:0]      din_dly_q  [SYNC_DEPTH];
  logic [pADDR_WIDTH-1:0] addr_dly;
  logic [DATA_W-1:0]      din_dly;

  always_ff @(posedge usb_clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_DEPTH; i++) begin
        addr_dly_q[i] <= '0;
        din_dly_q[i]  <= '0;
      end
    end else begin
      addr_dly_q[0] <= usb_addr;
      din_dly_q[0]  <= usb_din;
      for (int unsigned i = 1; i < SYNC_DEPTH; i++) begin
        addr_dly_q[i] <= addr_dly_q[i-1];
        din_dly_q[i]  <= din_dly_q[i-1];
      end
    end
  end

  assign addr_dly = addr_dly_q[SYNC_DEPTH-1];
  assign din_dly  = din_dly_q[SYNC_DEPTH-1];

  // State and output registers
  logic [STATE_W-1:0]     state_q, state_d;
  logic [pADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      datao_q, datao_d;
  logic [DATA_W-1:0]      dout_q, dout_d;
  logic                   isout_q, isout_d;
  logic                   read_q, read_d;
  logic                   write_q, write_d;
  logic                   addrvalid_q, addrvalid_d;
  logic                   first_q, first_d;
  logic [PROTO_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [FLUSH_W-1:0]     flush_q, flush_d;
  logic                   arm_q, arm_d;
  logic                   flush_done;

  // The synchroniser resets to "inactive", so the first SYNC_DEPTH cycles after
  // reset do not reflect the pins; arming waits until they do and both
  // strobes are genuinely high.
  assign flush_done = (flush_q == FLUSH_W'(SYNC_DEPTH));
  assign illegal    = arm_q & both_low & ~both_low_prev;

  always_ff @(posedge usb_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      datao_q     <= '0;
      dout_q      <= '0;
      isout_q     <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addrvalid_q <= 1'b0;
      first_q     <= 1'b0;
      err_cnt_q   <= '0;
      flush_q     <= '0;
      arm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      datao_q     <= datao_d;
      dout_q      <= dout_d;
      isout_q     <= isout_d;
      read_q      <= read_d;
      write_q     <= write_d;
      addrvalid_q <= addrvalid_d;
      first_q     <= first_d;
      err_cnt_q   <= err_cnt_d;
      flush_q     <= flush_d;
      arm_q       <= arm_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    datao_d     = datao_q;
    dout_d      = dout_q;
    isout_d     = 1'b0;
    read_d      = 1'b0;
    write_d     = 1'b0;
    addrvalid_d = addrvalid_q;
    first_d     = 1'b0;
    err_cnt_d   = err_cnt_q;
    flush_d     = flush_done ? flush_q : flush_q + FLUSH_W'(1);
    arm_d       = arm_q | (flush_done & rdn_s & wrn_s);

    case (state_q)
      ST_IDLE: begin
        if (arm_q && !cen_s) begin
          if (wrn_fall) begin
            state_d = ST_WR_ACTIVE;
          end else if (rdn_fall) begin
            state_d     = ST_RD_REQ;
            read_d      = 1'b1;
            addr_d      = addr_dly;
            addrvalid_d = 1'b1;
          end
        end
      end

      ST_WR_ACTIVE: begin
        // Capture only while wrn is still low so data changing with the
        // rising edge is never taken.
        if (!wrn_s) begin
          addr_d      = addr_dly;
          datao_d     = din_dly;
          addrvalid_d = 1'b1;
        end
        if (wrn_rise) begin
          state_d     = ST_IDLE;
          write_d     = 1'b1;
          addrvalid_d = 1'b0;
        end
      end

      ST_RD_REQ: begin
        state_d = ST_RD_DRIVE;
        isout_d = 1'b1;
        first_d = 1'b1;
      end

      ST_RD_DRIVE: begin
        isout_d = 1'b1;
        // reg_datai is valid on the first RD_DRIVE cycle; hold it afterwards.
        if (first_q) begin
          dout_d = reg_datai;
        end
        if (rdn_rise || cen_rise) begin
          state_d     = ST_IDLE;
          isout_d     = 1'b0;
          addrvalid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Both strobes low abandons whatever is in flight.
    if (illegal) begin
      state_d     = ST_IDLE;
      read_d      = 1'b0;
      write_d     = 1'b0;
      isout_d     = 1'b0;
      first_d     = 1'b0;
      addrvalid_d = 1'b0;
      err_cnt_d   = sat_inc(err_cnt_q);
    end
  end

  assign usb_dout      = dout_q;
  assign usb_isout     = isout_q;
  assign reg_address   = addr_q[pADDR_WIDTH-1:pBYTECNT_SIZE];
  assign reg_bytecnt   = addr_q[pBYTECNT_SIZE-1:0];
  assign reg_datao     = datao_q;
  assign reg_read      = read_q;
  assign reg_write     = write_q;
  assign reg_addrvalid = addrvalid_q;
  assign proto_err_cnt = err_cnt_q;

endmodule
